// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin arbiter serialising ball/paddle/block rectangle commands onto one plot engine.
// Latency: grant is combinational in IDLE; first plot_start can issue the cycle after grant; done follows the last plot_done by one cycle.
// Backpressure: requesters hold req until grant; commands stall while plot_busy=1; a watchdog bounds every engine wait.
// Optional erase-before-draw phase is built only when PLOT_ARBITER_ERASE_EN is defined.
module plot_arbiter #(
    parameter logic [2:0] ERASE_COLOUR   = 3'b000,
    parameter logic [2:0] BALL_COLOUR    = 3'b111,
    parameter logic [2:0] PADDLE_COLOUR  = 3'b010,
    parameter logic [2:0] BLOCK_COLOUR   = 3'b100,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter int         MAX_X          = 159,
    parameter int         MAX_Y          = 119
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_newX,
    input  logic [20:0] req_newY,
    input  logic [23:0] req_oldX,
    input  logic [20:0] req_oldY,
    input  logic [23:0] req_sizeX,
    input  logic [20:0] req_sizeY,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic [7:0]  plot_x,
    output logic [6:0]  plot_y,
    output logic [7:0]  plot_w,
    output logic [6:0]  plot_h,
    output logic [2:0]  plot_colour,
    output logic        plot_start,
    input  logic        plot_busy,
    input  logic        plot_done,
    output logic [1:0]  object,
    output logic        busy,
    output logic        timeout_err
);

    // Watchdog counts 0 .. TIMEOUT_CYCLES-1 inside a wait state.
    localparam int                WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    // Screen limits, widened by one bit so MAX+1 never wraps.
    localparam logic [8:0] X_LAST = 9'(MAX_X);
    localparam logic [8:0] X_END  = 9'(MAX_X + 1);
    localparam logic [7:0] Y_LAST = 8'(MAX_Y);
    localparam logic [7:0] Y_END  = 8'(MAX_Y + 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ERASE_START = 3'd1,
        ERASE_WAIT  = 3'd2,
        DRAW_START  = 3'd3,
        DRAW_WAIT   = 3'd4,
        FINISH      = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Owner of the operation in progress (also the round-robin pointer).
    logic [1:0]      last_winner;

    // Coordinates latched at grant so later req changes cannot disturb the operation.
    logic [7:0]      new_x;
    logic [6:0]      new_y;
    logic [7:0]      old_x;
    logic [6:0]      old_y;
    logic [7:0]      size_x;
    logic [6:0]      size_y;

    // Last issued command, presented on the plot outputs between strobes.
    logic [7:0]      hold_x;
    logic [6:0]      hold_y;
    logic [7:0]      hold_w;
    logic [6:0]      hold_h;
    logic [2:0]      hold_colour;

    logic [WD_W-1:0] wd;
    logic            in_wait;
    logic            wd_fire;

    logic [1:0]      pick;
    logic            pick_vld;
    logic [1:0]      cand;

    logic            erase_phase;
    logic [7:0]      cmd_x;
    logic [6:0]      cmd_y;
    logic [7:0]      cmd_w;
    logic [6:0]      cmd_h;
    logic [2:0]      cmd_colour;
    logic            cmd_empty;
    logic [8:0]      avail_x;
    logic [7:0]      avail_y;

    function automatic logic [7:0] sel8(input logic [23:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[7:0];
            2'd1:    return v[15:8];
            default: return v[23:16];
        endcase
    endfunction

    function automatic logic [6:0] sel7(input logic [20:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[6:0];
            2'd1:    return v[13:7];
            default: return v[20:14];
        endcase
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] i);
        case (i)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] i);
        case (i)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Round-robin search starting one past the previous winner.
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        cand     = rr_next(last_winner);
        for (int k = 0; k < 3; k++) begin
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

    // Current phase command: position, colour and clipped size.
    always_comb begin
        erase_phase = (state == ERASE_START) || (state == ERASE_WAIT);
        cmd_x       = erase_phase ? old_x : new_x;
        cmd_y       = erase_phase ? old_y : new_y;
        if (erase_phase) begin
            cmd_colour = ERASE_COLOUR;
        end else begin
            case (last_winner)
                2'd0:    cmd_colour = BALL_COLOUR;
                2'd1:    cmd_colour = PADDLE_COLOUR;
                default: cmd_colour = BLOCK_COLOUR;
            endcase
        end
        avail_x   = ({1'b0, cmd_x} > X_LAST) ? 9'd0 : (X_END - {1'b0, cmd_x});
        avail_y   = ({1'b0, cmd_y} > Y_LAST) ? 8'd0 : (Y_END - {1'b0, cmd_y});
        cmd_w     = ({1'b0, size_x} < avail_x) ? size_x : avail_x[7:0];
        cmd_h     = ({1'b0, size_y} < avail_y) ? size_y : avail_y[6:0];
        cmd_empty = (cmd_w == 8'd0) || (cmd_h == 7'd0);
    end

    assign in_wait = (state == ERASE_WAIT) || (state == DRAW_WAIT);
    assign wd_fire = in_wait && !plot_done && (wd == WD_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe outputs.
    always_comb begin
        state_nxt  = state;
        grant      = 3'b000;
        done       = 3'b000;
        plot_start = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant = onehot3(pick);
`ifdef PLOT_ARBITER_ERASE_EN
                    state_nxt = ERASE_START;
`else
                    state_nxt = DRAW_START;
`endif
                end
            end
            ERASE_START: begin
                if (cmd_empty) begin
                    state_nxt = DRAW_START;
                end else if (!plot_busy) begin
                    plot_start = 1'b1;
                    state_nxt  = ERASE_WAIT;
                end
            end
            ERASE_WAIT: begin
                if (plot_done || wd_fire) begin
                    state_nxt = DRAW_START;
                end
            end
            DRAW_START: begin
                if (cmd_empty) begin
                    state_nxt = FINISH;
                end else if (!plot_busy) begin
                    plot_start = 1'b1;
                    state_nxt  = DRAW_WAIT;
                end
            end
            DRAW_WAIT: begin
                if (plot_done || wd_fire) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = onehot3(last_winner);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch winner and its coordinates when a grant is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_winner <= 2'd2;
            new_x       <= 8'd0;
            new_y       <= 7'd0;
            old_x       <= 8'd0;
            old_y       <= 7'd0;
            size_x      <= 8'd0;
            size_y      <= 7'd0;
        end else if ((state == IDLE) && pick_vld) begin
            last_winner <= pick;
            new_x       <= sel8(req_newX, pick);
            new_y       <= sel7(req_newY, pick);
            old_x       <= sel8(req_oldX, pick);
            old_y       <= sel7(req_oldY, pick);
            size_x      <= sel8(req_sizeX, pick);
            size_y      <= sel7(req_sizeY, pick);
        end
    end

    // Remember each issued command so the outputs stay stable between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_x      <= 8'd0;
            hold_y      <= 7'd0;
            hold_w      <= 8'd0;
            hold_h      <= 7'd0;
            hold_colour <= 3'd0;
        end else if (plot_start) begin
            hold_x      <= cmd_x;
            hold_y      <= cmd_y;
            hold_w      <= cmd_w;
            hold_h      <= cmd_h;
            hold_colour <= cmd_colour;
        end
    end

    // Watchdog: restart on every wait entry, flag a sticky error when it expires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (in_wait && !plot_done && !wd_fire) begin
                wd <= wd + WD_W'(1);
            end else begin
                wd <= '0;
            end
            if (wd_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Plot outputs: live command during the strobe, held command otherwise.
    always_comb begin
        plot_x      = plot_start ? cmd_x      : hold_x;
        plot_y      = plot_start ? cmd_y      : hold_y;
        plot_w      = plot_start ? cmd_w      : hold_w;
        plot_h      = plot_start ? cmd_h      : hold_h;
        plot_colour = plot_start ? cmd_colour : hold_colour;
    end

    assign busy   = (state != IDLE);
    assign object = busy ? last_winner : 2'b11;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: a request-level model predicts grants, clipped commands and dones.
// Stimulus drives inputs 1 time unit after the rising edge; the monitor samples on the falling edge.
// A behavioural plot engine answers plot_start with plot_done after a programmable latency.
module tb_plot_arbiter;

    localparam int TO     = 16;
    localparam int MAXX   = 159;
    localparam int MAXY   = 119;
`ifdef PLOT_ARBITER_ERASE_EN
    localparam int PH     = 2;
`else
    localparam int PH     = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [23:0] req_newX = '0, req_oldX = '0, req_sizeX = '0;
    logic [20:0] req_newY = '0, req_oldY = '0, req_sizeY = '0;
    logic [2:0]  grant, done;
    logic [7:0]  plot_x, plot_w;
    logic [6:0]  plot_y, plot_h;
    logic [2:0]  plot_colour;
    logic        plot_start;
    logic        plot_busy = 1'b0;
    logic        plot_done = 1'b0;
    logic [1:0]  object;
    logic        busy, timeout_err;

    plot_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_newX(req_newX), .req_newY(req_newY),
        .req_oldX(req_oldX), .req_oldY(req_oldY),
        .req_sizeX(req_sizeX), .req_sizeY(req_sizeY),
        .grant(grant), .done(done),
        .plot_x(plot_x), .plot_y(plot_y), .plot_w(plot_w), .plot_h(plot_h),
        .plot_colour(plot_colour), .plot_start(plot_start),
        .plot_busy(plot_busy), .plot_done(plot_done),
        .object(object), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int w; int h; int c; } cmd_t;

    cmd_t exp_cmd_q[$];
    int   exp_grant_q[$];
    int   exp_done_q[$];

    int n_checks = 0, n_fail = 0;
    int n_grants = 0, n_starts = 0, n_dones = 0;
    int cyc = 0, last_start_cyc = 0, last_done_cyc = 0;
    int model_last = 2;
    bit model_to = 1'b0;
    bit engine_on = 1'b1;
    int engine_lat = 3;
    int pend = 0;
    int draw_col [3] = '{7, 2, 4};

    logic [7:0] nx [3], ox [3], sx [3];
    logic [6:0] ny [3], oy [3], sy [3];

    task automatic check_eq(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic longint pk(input int x, input int y, input int w, input int h, input int c);
        return (longint'(x) << 25) | (longint'(y) << 18) | (longint'(w) << 10) | (longint'(h) << 3) | longint'(c);
    endfunction

    // Reference model: clipped extent and round-robin choice.
    function automatic int clip(input int pos, input int size, input int last);
        int room;
        if (pos > last) return 0;
        room = last + 1 - pos;
        return (size < room) ? size : room;
    endfunction

    function automatic int rr(input int last, input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (last + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic push_cmd(input int x, input int y, input int sw, input int sh, input int c);
        cmd_t e;
        e.x = x; e.y = y; e.c = c;
        e.w = clip(x, sw, MAXX);
        e.h = clip(y, sh, MAXY);
        if (e.w > 0 && e.h > 0) begin
            exp_cmd_q.push_back(e);
            if (!engine_on) model_to = 1'b1;
        end
    endtask

    task automatic push_exp(input int w);
        exp_grant_q.push_back(w);
        if (PH == 2) push_cmd(ox[w], oy[w], sx[w], sy[w], 0);
        push_cmd(nx[w], ny[w], sx[w], sy[w], draw_col[w]);
        exp_done_q.push_back(w);
    endtask

    task automatic drive_coords();
        req_newX  = {nx[2], nx[1], nx[0]};
        req_oldX  = {ox[2], ox[1], ox[0]};
        req_sizeX = {sx[2], sx[1], sx[0]};
        req_newY  = {ny[2], ny[1], ny[0]};
        req_oldY  = {oy[2], oy[1], oy[0]};
        req_sizeY = {sy[2], sy[1], sy[0]};
    endtask

    task automatic set_req(input int i, input int x0, input int y0, input int x1, input int y1,
                           input int w, input int h);
        ox[i] = 8'(x0); oy[i] = 7'(y0); nx[i] = 8'(x1); ny[i] = 7'(y1);
        sx[i] = 8'(w);  sy[i] = 7'(h);
    endtask

    task automatic randomize_coords();
        for (int i = 0; i < 3; i++) begin
            nx[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(140, 255)) : 8'($urandom_range(0, 159));
            ox[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(140, 255)) : 8'($urandom_range(0, 159));
            ny[i] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(0, 119));
            oy[i] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(0, 119));
            sx[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
            sy[i] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 24));
        end
    endtask

    function automatic int cnt_of(input int sel);
        case (sel)
            0:       return n_grants;
            1:       return n_starts;
            default: return n_dones;
        endcase
    endfunction

    // Bounded wait on a monitor counter; returns 1 time unit after a rising edge.
    task automatic wait_for(input int sel, input int target, input int budget, input string name);
        int i;
        i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (cnt_of(sel) < target && i < budget);
        #1;
        check_eq(name, cnt_of(sel), target);
    endtask

    // One request pattern from IDLE through done; optionally scramble inputs after grant.
    task automatic run_txn(input logic [2:0] r, input bit scramble);
        int w, bg, bd;
        bg = n_grants; bd = n_dones;
        drive_coords();
        req = r;
        w = rr(model_last, r);
        model_last = w;
        push_exp(w);
        wait_for(0, bg + 1, 20, "wait_grant");
        req = 3'b000;
        if (scramble) begin
            randomize_coords();
            drive_coords();
        end
        wait_for(2, bd + 1, 200, "wait_done");
        check_eq("timeout_err", timeout_err, model_to);
    endtask

    // Plot engine: plot_done engine_lat cycles after each accepted plot_start.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && plot_start && engine_on) pend = engine_lat;
            @(posedge clk);
            #1;
            plot_done = 1'b0;
            if (reset) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) plot_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents grant, plot_start or done.
    initial begin
        int active, nxt;
        cmd_t e;
        longint hold;
        active = -1;
        hold = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check_eq("rst_grant", grant, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_plot_start", plot_start, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_object", object, 3);
                check_eq("rst_timeout_err", timeout_err, 0);
                check_eq("rst_plot_fields", pk(plot_x, plot_y, plot_w, plot_h, plot_colour), 0);
                exp_cmd_q.delete();
                exp_grant_q.delete();
                exp_done_q.delete();
                active = -1;
                hold = 0;
            end else begin
                check_eq("busy", busy, (active >= 0) ? 1 : 0);
                check_eq("object", object, (active >= 0) ? active : 3);
                nxt = active;
                if (grant != 0) begin
                    n_grants++;
                    if (exp_grant_q.size() == 0) begin
                        check_eq("grant_unexpected", grant, 0);
                    end else begin
                        nxt = exp_grant_q.pop_front();
                        check_eq("grant", grant, 1 << nxt);
                    end
                end
                if (plot_start) begin
                    n_starts++;
                    last_start_cyc = cyc;
                    check_eq("start_while_busy", plot_busy, 0);
                    if (exp_cmd_q.size() == 0) begin
                        check_eq("start_unexpected", plot_start, 0);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        hold = pk(e.x, e.y, e.w, e.h, e.c);
                        check_eq("plot_cmd", pk(plot_x, plot_y, plot_w, plot_h, plot_colour), hold);
                    end
                end else begin
                    check_eq("plot_hold", pk(plot_x, plot_y, plot_w, plot_h, plot_colour), hold);
                end
                if (done != 0) begin
                    n_dones++;
                    last_done_cyc = cyc;
                    if (exp_done_q.size() == 0) begin
                        check_eq("done_unexpected", done, 0);
                    end else begin
                        check_eq("done", done, 1 << exp_done_q.pop_front());
                        nxt = -1;
                    end
                end
                active = nxt;
            end
        end
    end

    // Global guard so the run always ends.
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "global timeout");
    end

    // Stimulus.
    initial begin
        int bg, bd, bs, w, drop_cyc;
        for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0, 0, 0, 0);
        drive_coords();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Ball: erase (50,4) 4x4 then draw (51,5) 4x4 in white.
        set_req(0, 50, 4, 51, 5, 4, 4);
        run_txn(3'b001, 1'b0);
        check_eq("ball_start_to_done", last_done_cyc - last_start_cyc, engine_lat + 1);

        // Paddle clipped at the right edge; block fully off-screen.
        set_req(1, 150, 100, 150, 100, 20, 10);
        run_txn(3'b010, 1'b0);
        bs = n_starts;
        set_req(2, 200, 10, 200, 10, 8, 4);
        run_txn(3'b100, 1'b0);
        check_eq("offscreen_starts", n_starts, bs);

        // All three requesting continuously: round-robin order 0,1,2,0.
        set_req(0, 10, 10, 12, 11, 4, 4);
        set_req(1, 60, 110, 62, 110, 16, 4);
        set_req(2, 100, 20, 100, 20, 8, 4);
        drive_coords();
        bg = n_grants; bd = n_dones; bs = n_starts;
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            w = rr(model_last, 3'b111);
            model_last = w;
            push_exp(w);
        end
        wait_for(0, bg + 4, 200, "wait_rr_grants");
        req = 3'b000;
        wait_for(2, bd + 4, 200, "wait_rr_dones");
        check_eq("rr_starts_per_grant", n_starts - bs, 4 * PH);

        // plot_busy held for 10 command cycles.
        set_req(0, 20, 30, 21, 31, 5, 5);
        drive_coords();
        bg = n_grants; bd = n_dones; bs = n_starts;
        plot_busy = 1'b1;
        req = 3'b001;
        w = rr(model_last, 3'b001);
        model_last = w;
        push_exp(w);
        wait_for(0, bg + 1, 20, "wait_busy_grant");
        req = 3'b000;
        repeat (10) @(posedge clk);
        #1;
        check_eq("no_start_while_busy", n_starts, bs);
        drop_cyc = cyc + 1;
        plot_busy = 1'b0;
        wait_for(1, bs + 1, 10, "wait_busy_start");
        check_eq("start_after_busy", last_start_cyc, drop_cyc);
        wait_for(2, bd + 1, 100, "wait_busy_done");
        check_eq("timeout_err_busy", timeout_err, model_to);

        // Engine never answers: watchdog completes the operation.
        engine_on = 1'b0;
        set_req(1, 30, 40, 31, 40, 6, 3);
        run_txn(3'b010, 1'b0);
        check_eq("timeout_start_to_done", last_done_cyc - last_start_cyc, TO + 1);
        engine_on = 1'b1;

        // Randomised requests, coordinates and engine latency; inputs scrambled after grant.
        for (int t = 0; t < 40; t++) begin
            engine_lat = $urandom_range(1, 6);
            randomize_coords();
            run_txn(3'($urandom_range(1, 7)), 1'b1);
        end
        engine_lat = 3;

        // Reset in DRAW_WAIT abandons the paddle operation; next grant goes to requester 0.
        set_req(1, 40, 50, 41, 50, 6, 6);
        drive_coords();
        bg = n_grants; bd = n_dones; bs = n_starts;
        req = 3'b010;
        w = rr(model_last, 3'b010);
        model_last = w;
        push_exp(w);
        wait_for(0, bg + 1, 20, "wait_rst_grant");
        req = 3'b000;
        wait_for(1, bs + PH, 60, "wait_rst_draw_start");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_last = 2;
        model_to = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("no_done_after_reset", n_dones, bd);
        set_req(0, 5, 5, 6, 6, 3, 3);
        set_req(1, 70, 70, 71, 70, 3, 3);
        set_req(2, 90, 10, 90, 10, 3, 3);
        run_txn(3'b111, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("scoreboard_cmd_left", exp_cmd_q.size(), 0);
        check_eq("scoreboard_done_left", exp_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter ERASE_COLOUR, default 3'b000, SHALL be the colour used to erase a requester's old rectangle.
REQ-002 Parameters BALL_COLOUR/PADDLE_COLOUR/BLOCK_COLOUR, defaults 3'b111/3'b010/3'b100, SHALL be the draw colours for requesters 0/1/2.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, SHALL be the maximum cycles to wait for plot_done.
REQ-004 Parameters MAX_X = 159 and MAX_Y = 119 SHALL be the last visible column and row.
REQ-005 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  3  per-requester draw request (bit0 ball, bit1 paddle, bit2 block), held high with stable coordinates until grant.
REQ-008 req_newX/req_oldX  in  24  three packed 8-bit X fields; requester i uses bits [8i+7:8i].
REQ-009 req_newY/req_oldY  in  21  three packed 7-bit Y fields; requester i uses bits [7i+6:7i].
REQ-010 req_sizeX  in  24, req_sizeY  in  21  packed rectangle width/height per requester.
REQ-011 grant  out  3  one-hot, one-cycle accept pulse.
REQ-012 done  out  3  one-hot, one-cycle completion pulse for the granted requester.
REQ-013 plot_x  out  8, plot_y  out  7, plot_w  out  8, plot_h  out  7, plot_colour  out  3  rectangle command to the plot engine.
REQ-014 plot_start  out  1  one-cycle command strobe; plot_busy  in  1; plot_done  in  1  engine completion pulse.
REQ-015 object  out  2  active object (00 ball, 01 paddle, 10 block, 11 none); busy  out  1; timeout_err  out  1  sticky.

Function
REQ-016 FSM states SHALL be IDLE, ERASE_START, ERASE_WAIT, DRAW_START, DRAW_WAIT, FINISH.
REQ-017 IDLE with req != 0: winner chosen round-robin, searching upward from (last_winner+1) mod 3; grant[winner] pulses, all six coordinate fields latched, last_winner updated, next state ERASE_START.
REQ-018 ERASE_START: when plot_busy = 0, plot_start pulses with latched old X/Y, size, ERASE_COLOUR, next state ERASE_WAIT; while plot_busy = 1, state held and plot_start stays 0.
REQ-019 ERASE_WAIT: on plot_done, next state DRAW_START.
REQ-020 DRAW_START/DRAW_WAIT: same as REQ-018/019 using new X/Y and the winner's draw colour; plot_done advances to FINISH.
REQ-021 FINISH: done[winner] pulses one cycle, next state IDLE; a new grant is possible no earlier than the following cycle.
REQ-022 Clipping: width = min(sizeX, MAX_X+1-x) and height = min(sizeY, MAX_Y+1-y), computed at 9/8-bit width with no wrap; x > MAX_X or y > MAX_Y gives size 0.
REQ-023 A phase whose clipped width or height is 0 SHALL issue no plot_start and SHALL advance directly to the next phase in one cycle.
REQ-024 plot_done SHALL be ignored outside the WAIT states.
REQ-025 Watchdog: in a WAIT state, after TIMEOUT_CYCLES cycles without plot_done, timeout_err is set and the FSM advances as if plot_done had occurred.
REQ-026 req changes after grant SHALL NOT affect the operation in progress.
REQ-027 busy = 1 in every state except IDLE; object = winner code when busy = 1, else 11.
REQ-028 Plot outputs SHALL hold their last values between strobes.

Reset
REQ-029 Reset SHALL force IDLE, grant = 0, done = 0, plot_start = 0, plot_x/y/w/h = 0, plot_colour = 0, object = 11, busy = 0, timeout_err = 0, watchdog = 0, last_winner = 2.
REQ-030 Reset asserted mid-operation SHALL abandon the operation without issuing done.

Configuration
REQ-031 With macro PLOT_ARBITER_ERASE_EN defined, the erase phase (REQ-018/019) SHALL exist as specified.
REQ-032 Without it, IDLE SHALL go directly to DRAW_START, ERASE_START/ERASE_WAIT SHALL be unreachable, and ERASE_COLOUR SHALL be unused.

Verification
REQ-033 req=3'b111 held, engine returning plot_done 3 cycles after each start -> grant order 001, 010, 100, 001; exactly 2 plot_starts per grant.
REQ-034 Ball: old (50,4), new (51,5), size 4x4 -> erase (50,4,4,4, colour 000), then draw (51,5,4,4, colour 111), then done=001.
REQ-035 Paddle: x=150, sizeX=20 -> plot_w=10; block at x=200 -> no plot_start in either phase, done still pulses.
REQ-036 plot_busy held high for 10 cycles in ERASE_START -> plot_start stays 0, then pulses once in the cycle after busy falls.
REQ-037 plot_done never returned, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT cycles, FSM completes, done pulses.
REQ-038 Reset pulsed in DRAW_WAIT -> state IDLE, object=11, no done pulse, and the next grant goes to requester 0.
